// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer for the ARM-subset CPU.
// Walks FETCH -> DECODE -> EXECUTE -> (MEMORY -> (WRITEBACK)) and drives every
// write enable, memory handshake and select line from the registered state.
// Memory waits are bounded by MEM_TIMEOUT; an expired wait parks the machine
// in a sticky FAULT state that only reset can leave.
module cpu_control_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      alu_ctl_code,
    input  logic             execute_flag,
    input  logic             s_bit,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             decoder_enable,
    output logic             ir_load,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             regfile_we,
    output logic             link_we,
    output logic             wb_sel,
    output logic             cpsr_we,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             undef_instr,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_DP, C_CMPC, C_B, C_BL, C_LDR, C_STR, C_UNDEF
    } cls_e;

    // The wait counter holds the number of ready-low cycles already spent in
    // the current state; the cycle that would make it reach MEM_TIMEOUT is the
    // last chance for ready, and ready in that cycle still counts as success.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             is_str_q, is_str_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             wait_expired;
    cls_e             cls;

    // Classify the decoder operation code.
    always_comb begin
        cls = C_UNDEF;
        case (alu_ctl_code)
            11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7,
            11'd11, 11'd12:                  cls = C_DP;
            11'd8, 11'd9, 11'd10, 11'd13:    cls = C_CMPC;
            11'd31:                          cls = C_B;
            11'd32:                          cls = C_BL;
            11'd41:                          cls = C_LDR;
            11'd42:                          cls = C_STR;
            default:                         cls = C_UNDEF;
        endcase
    end

    assign wait_expired = (wait_q == WAIT_LAST);

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_d        = state_q;
        wait_d         = 8'd0;
        is_str_d       = is_str_q;
        retire         = 1'b0;
        decoder_enable = 1'b0;
        ir_load        = 1'b0;
        imem_req       = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        regfile_we     = 1'b0;
        link_we        = 1'b0;
        wb_sel         = 1'b0;
        cpsr_we        = 1'b0;
        pc_write       = 1'b0;
        pc_sel         = 1'b0;
        undef_instr    = 1'b0;
        fault          = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                decoder_enable = 1'b1;
                state_d        = S_EXECUTE;
            end
            S_EXECUTE: begin
                decoder_enable = 1'b1;
                state_d        = S_FETCH;
                if (!execute_flag) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end else begin
                    case (cls)
                        C_DP: begin
                            regfile_we = 1'b1;
                            cpsr_we    = s_bit;
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                        end
                        C_CMPC: begin
                            cpsr_we  = 1'b1;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        C_B: begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                            retire   = 1'b1;
                        end
                        C_BL: begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                            link_we  = 1'b1;
                            retire   = 1'b1;
                        end
                        C_LDR, C_STR: begin
                            // Latch the direction so MEMORY never looks at the code again.
                            is_str_d = (cls == C_STR);
                            state_d  = S_MEMORY;
                        end
                        default: begin
                            undef_instr = 1'b1;
                            pc_write    = 1'b1;
                            retire      = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_str_q;
                if (dmem_ready) begin
                    if (is_str_q) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WRITEBACK;
                    end
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                regfile_we = 1'b1;
                wb_sel     = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

        if (!reset_n) begin
            decoder_enable = 1'b0;
            ir_load        = 1'b0;
            imem_req       = 1'b0;
            dmem_req       = 1'b0;
            dmem_we        = 1'b0;
            regfile_we     = 1'b0;
            link_we        = 1'b0;
            wb_sel         = 1'b0;
            cpsr_we        = 1'b0;
            pc_write       = 1'b0;
            pc_sel         = 1'b0;
            undef_instr    = 1'b0;
            fault          = 1'b0;
        end
    end

    assign state         = reset_n ? state_q : 3'd0;
    assign retired_count = reset_n ? cnt_q : '0;

    // State, wait counter, latched memory direction and retire counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            wait_q   <= 8'd0;
            is_str_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            is_str_q <= is_str_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer. Each stimulus cycle pushes its
// hand-computed expected output vector into a queue; a negedge monitor pops
// and compares against the DUT outputs.
// DUT runs with MEM_TIMEOUT=5 and CNT_W=2 so the count wrap, the
// ready-on-last-chance case and the bus timeout all fit in one short run.
module tb_cpu_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] alu_ctl_code = '0;
    logic        execute_flag = 1'b0;
    logic        s_bit = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        decoder_enable, ir_load, imem_req, dmem_req, dmem_we;
    logic        regfile_we, link_we, wb_sel, cpsr_we, pc_write, pc_sel;
    logic        undef_instr, fault;
    logic [2:0]  state;
    logic [1:0]  retired_count;

    cpu_control_sequencer #(.MEM_TIMEOUT(5), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .alu_ctl_code(alu_ctl_code),
        .execute_flag(execute_flag), .s_bit(s_bit), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .decoder_enable(decoder_enable), .ir_load(ir_load),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .regfile_we(regfile_we), .link_we(link_we), .wb_sel(wb_sel),
        .cpsr_we(cpsr_we), .pc_write(pc_write), .pc_sel(pc_sel),
        .undef_instr(undef_instr), .fault(fault), .state(state),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] DE   = 13'h1000;
    localparam logic [12:0] IR   = 13'h0800;
    localparam logic [12:0] IREQ = 13'h0400;
    localparam logic [12:0] DREQ = 13'h0200;
    localparam logic [12:0] DWE  = 13'h0100;
    localparam logic [12:0] RWE  = 13'h0080;
    localparam logic [12:0] LWE  = 13'h0040;
    localparam logic [12:0] WBS  = 13'h0020;
    localparam logic [12:0] CWE  = 13'h0010;
    localparam logic [12:0] PCW  = 13'h0008;
    localparam logic [12:0] PCS  = 13'h0004;
    localparam logic [12:0] UND  = 13'h0002;
    localparam logic [12:0] FLT  = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;

    typedef struct {
        logic [17:0] v;
        int          id;
    } exp_t;

    exp_t q[$];
    int   nstep = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Apply one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input logic rn, input logic [10:0] code, input logic ef,
                        input logic s, input logic ir, input logic dr,
                        input logic [12:0] fl, input logic [2:0] st, input logic [1:0] rc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n      = rn;
        alu_ctl_code = code;
        execute_flag = ef;
        s_bit        = s;
        imem_ready   = ir;
        dmem_ready   = dr;
        e.v  = {fl, st, rc};
        e.id = nstep;
        q.push_back(e);
        nstep++;
    endtask

    // Zero-wait fetch followed by decode.
    task automatic fd(input logic [1:0] rc);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, IREQ | IR, 3'd0, rc);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, DE, 3'd1, rc);
    endtask

    task automatic ex(input logic [10:0] code, input logic ef, input logic s,
                      input logic [12:0] fl, input logic [1:0] rc);
        step(1'b1, code, ef, s, 1'b0, 1'b0, DE | fl, 3'd2, rc);
    endtask

    // Monitor: every cycle with a queued expectation is a compared vector.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] got;
            e = q.pop_front();
            got = {decoder_enable, ir_load, imem_req, dmem_req, dmem_we, regfile_we,
                   link_we, wb_sel, cpsr_we, pc_write, pc_sel, undef_instr, fault,
                   state, retired_count};
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL vec%0d outputs: got %b expected %b (de,ir,ireq,dreq,dwe,rwe,lwe,wbs,cwe,pcw,pcs,und,flt,state,count)",
                         e.id, got, e.v);
            end
        end
    end

    initial begin
        // Reset held: everything low.
        step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 3'd0, 2'd0);
        step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 3'd0, 2'd0);

        // ADD with S: 3-cycle retire.
        fd(2'd0);
        ex(11'd0, 1'b1, 1'b1, RWE | CWE | PCW, 2'd0);
        // CMP with s_bit=0 still writes flags.
        fd(2'd1);
        ex(11'd8, 1'b1, 1'b0, CWE | PCW, 2'd1);
        // BL skipped by condition: PC+4 only.
        fd(2'd2);
        ex(11'd32, 1'b0, 1'b0, PCW, 2'd2);
        // Unknown code 20: undef pulse, count wraps 3 -> 0.
        fd(2'd3);
        ex(11'd20, 1'b1, 1'b0, UND | PCW, 2'd3);
        // B.
        fd(2'd0);
        ex(11'd31, 1'b1, 1'b0, PCW | PCS, 2'd0);
        // DP code 12 without S: no flag write.
        fd(2'd1);
        ex(11'd12, 1'b1, 1'b0, RWE | PCW, 2'd1);
        // BL taken.
        fd(2'd2);
        ex(11'd32, 1'b1, 1'b0, PCW | PCS | LWE, 2'd2);

        // Fetch with two wait cycles, then LDR with dmem_ready arriving on
        // the fifth MEMORY cycle (last chance before timeout) -> success.
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, IREQ, 3'd0, 2'd3);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, IREQ, 3'd0, 2'd3);
        fd(2'd3);
        ex(11'd41, 1'b1, 1'b0, NONE, 2'd3);
        // Code 42 during MEMORY must not turn the load into a store.
        for (int i = 0; i < 4; i++)
            step(1'b1, 11'd42, 1'b1, 1'b0, 1'b0, 1'b0, DREQ, 3'd3, 2'd3);
        step(1'b1, 11'd42, 1'b1, 1'b0, 1'b0, 1'b1, DREQ, 3'd3, 2'd3);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, RWE | WBS | PCW, 3'd4, 2'd3);

        // STR zero-wait: 4 cycles.
        fd(2'd0);
        ex(11'd42, 1'b1, 1'b0, NONE, 2'd0);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, DREQ | DWE | PCW, 3'd3, 2'd0);

        // LDR aborted by reset in MEMORY: no writeback pulse, count cleared.
        fd(2'd1);
        ex(11'd41, 1'b1, 1'b0, NONE, 2'd1);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, DREQ, 3'd3, 2'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, NONE, 3'd0, 2'd0);

        // STR with dmem_ready never asserted: five waits then sticky FAULT.
        fd(2'd0);
        ex(11'd42, 1'b1, 1'b0, NONE, 2'd0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, DREQ | DWE, 3'd3, 2'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, FLT, 3'd5, 2'd0);
        // Only reset clears the fault.
        step(1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, NONE, 3'd0, 2'd0);
        step(1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, IREQ | IR, 3'd0, 2'd0);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
